// File: rtl/core_pkg.sv
// Shared definitions for the core sequencer: FSM states, address width and
// bit positions of the 17-bit core instruction word.
package core_pkg;
    localparam int aw     = 4;
    localparam int INST_W = 17;

    localparam int OFIFO_RD_B = 16;
    localparam int QK_ADD_LSB = 12;
    localparam int P_ADD_LSB  = 8;
    localparam int EXECUTE_B  = 7;
    localparam int LOAD_B     = 6;
    localparam int QMEM_RD_B  = 5;
    localparam int QMEM_WR_B  = 4;
    localparam int KMEM_RD_B  = 3;
    localparam int KMEM_WR_B  = 2;
    localparam int PMEM_RD_B  = 1;
    localparam int PMEM_WR_B  = 0;

    typedef enum logic [2:0] {
        IDLE, WR_Q, WR_K, LOAD, LGAP, EXEC, DRAIN
    } seq_state_e;
endpackage

// File: rtl/core_sequencer.sv
// Attention-pass sequencer: writes Q/K, preloads K, executes Q rows, drains ofifo to pmem.
// inst is registered (one cycle after each beat); host stalls and empty ofifo insert zero words.
module core_sequencer #(
    parameter int col   = 8,
    parameter int bw    = 8,
    parameter int max_q = 16,
    parameter int aw    = core_pkg::aw
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          start,
    input  logic [aw-1:0] n_q,
    input  logic          in_valid,
    output logic          in_ready,
    input  logic          ofifo_valid,
    output logic [16:0]   inst,
    output logic          busy,
    output logic          done
);
    import core_pkg::*;

    localparam logic [aw-1:0] COL_LAST   = aw'(col - 1);
    localparam logic [aw-1:0] Q_LAST_MAX = aw'((bw > 0) ? max_q - 1 : 0);

    seq_state_e        state_q, state_d;
    logic [aw-1:0]     cnt_q, cnt_d;
    logic [aw-1:0]     pcnt_q, pcnt_d;
    logic [aw-1:0]     nq_q, nq_d;
    logic [INST_W-1:0] inst_q, inst_d;
    logic              done_q, done_d;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            pcnt_q  <= '0;
            nq_q    <= '0;
            inst_q  <= '0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            pcnt_q  <= pcnt_d;
            nq_q    <= nq_d;
            inst_q  <= inst_d;
            done_q  <= done_d;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        pcnt_d  = pcnt_q;
        nq_d    = nq_q;
        done_d  = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (start) begin
                    state_d = WR_Q;
                    nq_d    = (n_q > Q_LAST_MAX) ? Q_LAST_MAX : n_q;
                    cnt_d   = '0;
                    pcnt_d  = '0;
                end
            end
            WR_Q: begin
                if (in_valid) begin
                    if (cnt_q == nq_q) begin
                        cnt_d   = '0;
                        state_d = WR_K;
                    end else begin
                        cnt_d = cnt_q + aw'(1);
                    end
                end
            end
            WR_K: begin
                if (in_valid) begin
                    if (cnt_q == COL_LAST) begin
                        cnt_d   = '0;
                        state_d = LOAD;
                    end else begin
                        cnt_d = cnt_q + aw'(1);
                    end
                end
            end
            LOAD: begin
                if (cnt_q == COL_LAST) begin
                    cnt_d   = '0;
                    state_d = LGAP;
                end else begin
                    cnt_d = cnt_q + aw'(1);
                end
            end
            LGAP: state_d = EXEC;
            EXEC: begin
                if (cnt_q == nq_q) begin
                    cnt_d   = '0;
                    state_d = DRAIN;
                end else begin
                    cnt_d = cnt_q + aw'(1);
                end
            end
            DRAIN: begin
                if (ofifo_valid) begin
                    if (pcnt_q == nq_q) begin
                        state_d = IDLE;
                        done_d  = 1'b1;
                    end else begin
                        pcnt_d = pcnt_q + aw'(1);
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // inst_d is the word for the beat taken at the coming edge; it appears one cycle later.
    always_comb begin
        in_ready = (state_q == WR_Q) || (state_q == WR_K);
        busy     = (state_q != IDLE);
        inst_d   = '0;
        unique case (state_q)
            WR_Q: if (in_valid) begin
                inst_d[QMEM_WR_B]            = 1'b1;
                inst_d[QK_ADD_LSB +: aw]     = cnt_q;
            end
            WR_K: if (in_valid) begin
                inst_d[KMEM_WR_B]            = 1'b1;
                inst_d[QK_ADD_LSB +: aw]     = cnt_q;
            end
            LOAD: begin
                inst_d[KMEM_RD_B]            = 1'b1;
                inst_d[LOAD_B]               = 1'b1;
                inst_d[QK_ADD_LSB +: aw]     = cnt_q;
            end
            EXEC: begin
                inst_d[QMEM_RD_B]            = 1'b1;
                inst_d[EXECUTE_B]            = 1'b1;
                inst_d[QK_ADD_LSB +: aw]     = cnt_q;
            end
            DRAIN: if (ofifo_valid) begin
                inst_d[OFIFO_RD_B]           = 1'b1;
                inst_d[PMEM_WR_B]            = 1'b1;
                inst_d[P_ADD_LSB +: aw]      = pcnt_q;
            end
            default: ;
        endcase
        inst_d[PMEM_RD_B] = 1'b0;
    end

    assign inst = inst_q;
    assign done = done_q;
endmodule

// File: tb/tb_core_sequencer.sv
// Bench for core_sequencer: a queue of expected beats per pass, consumed as the host and ofifo allow.
module tb_core_sequencer;
    logic        clk = 1'b0;
    logic        reset, start, in_valid, ofifo_valid;
    logic [3:0]  n_q;
    logic        in_ready, busy, done;
    logic [16:0] inst;

    always #5 clk = ~clk;

    core_sequencer #(.col(8), .bw(8), .max_q(16), .aw(4)) dut (
        .clk(clk), .reset(reset), .start(start), .n_q(n_q),
        .in_valid(in_valid), .in_ready(in_ready), .ofifo_valid(ofifo_valid),
        .inst(inst), .busy(busy), .done(done)
    );

    localparam int COL = 8;
    typedef enum int {B_HOST, B_FREE, B_GAP, B_DRAIN} kind_e;
    typedef struct { kind_e kind; logic [16:0] w; } beat_t;

    beat_t       mq[$];
    logic [16:0] exp_inst = '0;
    logic        exp_done = 1'b0;
    int          checks = 0;
    int          failures = 0;

    function automatic logic [16:0] mkw(input logic [16:0] base, input int qk, input int pa);
        logic [16:0] w;
        w        = base;
        w[15:12] = qk[3:0];
        w[11:8]  = pa[3:0];
        return w;
    endfunction

    function automatic logic m_busy();
        return mq.size() != 0;
    endfunction

    function automatic logic m_rdy();
        return (mq.size() != 0) && (mq[0].kind == B_HOST);
    endfunction

    // A pass is the ordered list of instruction beats the host/ofifo must allow through.
    task automatic plan_pass(input int n);
        for (int i = 0; i <= n; i++)  mq.push_back('{B_HOST, mkw(17'h00010, i, 0)});
        for (int i = 0; i < COL; i++) mq.push_back('{B_HOST, mkw(17'h00004, i, 0)});
        for (int i = 0; i < COL; i++) mq.push_back('{B_FREE, mkw(17'h00048, i, 0)});
        mq.push_back('{B_GAP, 17'h0});
        for (int i = 0; i <= n; i++)  mq.push_back('{B_FREE, mkw(17'h000A0, i, 0)});
        for (int i = 0; i <= n; i++)  mq.push_back('{B_DRAIN, mkw(17'h10001, 0, i)});
    endtask

    task automatic step(input logic iv, input logic ov, input logic st, input logic [3:0] nq);
        in_valid = iv; ofifo_valid = ov; start = st; n_q = nq;
        exp_inst = '0;
        exp_done = 1'b0;
        if (mq.size() == 0) begin
            if (st) plan_pass(int'(nq));
        end else begin
            case (mq[0].kind)
                B_HOST:  if (iv) begin exp_inst = mq[0].w; mq.delete(0); end
                B_FREE:  begin exp_inst = mq[0].w; mq.delete(0); end
                B_GAP:   mq.delete(0);
                B_DRAIN: if (ov) begin
                    exp_inst = mq[0].w; mq.delete(0);
                    exp_done = (mq.size() == 0);
                end
                default: ;
            endcase
        end
        @(negedge clk);
    endtask

    task automatic test_reset();
        int n;
        repeat (2) @(negedge clk);
        checks++;
        if ({inst, busy, in_ready, done} !== 20'h0) begin
            failures++;
            $display("FAIL reset_state: got %h %b %b %b want all zero", inst, busy, in_ready, done);
        end
        reset = 1'b0;
        @(negedge clk);
        step(1, 1, 1, 4'd3);
        for (n = 0; n < 23; n++) begin
            step(1, 1, 0, 4'd0);
            checks++;
            if ({inst, busy, in_ready, done} !== {exp_inst, m_busy(), m_rdy(), exp_done}) begin
                failures++;
                $display("FAIL pre_reset step %0d: got %h %b %b %b want %h %b %b %b", n, inst, busy,
                         in_ready, done, exp_inst, m_busy(), m_rdy(), exp_done);
            end
        end
        #2 reset = 1'b1;
        #1;
        checks++;
        if ({inst, busy, in_ready} !== 19'h0) begin
            failures++;
            $display("FAIL async_reset: got inst=%h busy=%b in_ready=%b want 0 0 0", inst, busy, in_ready);
        end
        @(negedge clk);
        reset = 1'b0;
        mq.delete();
        step(1, 1, 1, 4'd3);
        for (n = 0; n < 200; n++) begin
            checks++;
            if ({inst, busy, in_ready, done} !== {exp_inst, m_busy(), m_rdy(), exp_done}) begin
                failures++;
                $display("FAIL restart step %0d: got %h %b %b %b want %h %b %b %b", n, inst, busy,
                         in_ready, done, exp_inst, m_busy(), m_rdy(), exp_done);
            end
            if (done === 1'b1) break;
            step(1, 1, 0, 4'd0);
        end
        checks++;
        if (n >= 200) begin failures++; $display("FAIL restart_timeout: no done within %0d cycles", n); end
    endtask

    task automatic test_full_pass();
        int n;
        step(1, 1, 1, 4'd7);
        for (n = 1; n <= 200; n++) begin
            checks++;
            if ({inst, busy, in_ready, done} !== {exp_inst, m_busy(), m_rdy(), exp_done}) begin
                failures++;
                $display("FAIL full_pass cycle %0d: got %h %b %b %b want %h %b %b %b", n, inst, busy,
                         in_ready, done, exp_inst, m_busy(), m_rdy(), exp_done);
            end
            if (done === 1'b1) break;
            step(1, 1, 0, 4'd0);
        end
        checks++;
        if (n != 42) begin failures++; $display("FAIL full_pass_done_cycle: got %0d want 42", n); end
    endtask

    task automatic test_host_stalls();
        int n, qw, kw;
        qw = 0; kw = 0;
        step(1, 1, 1, 4'd1);
        for (n = 0; n < 200; n++) begin
            checks++;
            if ({inst, busy, in_ready, done} !== {exp_inst, m_busy(), m_rdy(), exp_done}) begin
                failures++;
                $display("FAIL host_stalls step %0d: got %h %b %b %b want %h %b %b %b", n, inst, busy,
                         in_ready, done, exp_inst, m_busy(), m_rdy(), exp_done);
            end
            qw += int'(inst[4]);
            kw += int'(inst[2]);
            if (done === 1'b1) break;
            step(n[0], 1, 0, 4'd0);
        end
        checks++;
        if (qw != 2 || kw != 8) begin
            failures++;
            $display("FAIL host_stall_counts: got qmem_wr=%0d kmem_wr=%0d want 2 8", qw, kw);
        end
    endtask

    task automatic test_drain_backpressure();
        int n, low, bad;
        logic ov, prev_ov;
        int padd[$];
        low = 0; bad = 0; prev_ov = 1'b0;
        step(1, 0, 1, 4'd2);
        for (n = 0; n < 200; n++) begin
            checks++;
            if ({inst, busy, in_ready, done} !== {exp_inst, m_busy(), m_rdy(), exp_done}) begin
                failures++;
                $display("FAIL drain_bp step %0d: got %h %b %b %b want %h %b %b %b", n, inst, busy,
                         in_ready, done, exp_inst, m_busy(), m_rdy(), exp_done);
            end
            if (inst[16] === 1'b1) begin
                if (!prev_ov) bad++;
                padd.push_back(int'(inst[11:8]));
            end
            if (done === 1'b1) break;
            ov = 1'b0;
            if (mq.size() != 0 && mq[0].kind == B_DRAIN) begin
                ov = (low >= 5);
                low++;
            end
            prev_ov = ov;
            step(1, ov, 0, 4'd0);
        end
        checks++;
        if (bad != 0 || padd.size() != 3 || padd[0] != 0 || padd[1] != 1 || padd[2] != 2) begin
            failures++;
            $display("FAIL drain_bp_order: reads_while_low=%0d beats=%0d want 0 reads, pmem_add 0,1,2",
                     bad, padd.size());
        end
    endtask

    task automatic test_boundaries();
        int n, qw, ex, dr, qmax;
        int cfg[2] = '{15, 0};
        foreach (cfg[c]) begin
            qw = 0; ex = 0; dr = 0; qmax = 0;
            step(1, 1, 1, 4'(cfg[c]));
            for (n = 0; n < 400; n++) begin
                checks++;
                if ({inst, busy, in_ready, done} !== {exp_inst, m_busy(), m_rdy(), exp_done}) begin
                    failures++;
                    $display("FAIL boundary n_q=%0d step %0d: got %h %b %b %b want %h %b %b %b", cfg[c], n,
                             inst, busy, in_ready, done, exp_inst, m_busy(), m_rdy(), exp_done);
                end
                if (inst[4] === 1'b1) begin
                    qw++;
                    if (int'(inst[15:12]) > qmax) qmax = int'(inst[15:12]);
                end
                ex += int'(inst[7]);
                dr += int'(inst[16]);
                if (done === 1'b1) break;
                step($urandom_range(0, 3) != 0, $urandom_range(0, 2) != 0, 0, 4'd0);
            end
            checks++;
            if (qw != cfg[c] + 1 || ex != cfg[c] + 1 || dr != cfg[c] + 1 || qmax != cfg[c]) begin
                failures++;
                $display("FAIL boundary_counts n_q=%0d: qw=%0d ex=%0d dr=%0d qmax=%0d want %0d each, qmax %0d",
                         cfg[c], qw, ex, dr, qmax, cfg[c] + 1, cfg[c]);
            end
        end
    endtask

    task automatic test_ignored_start();
        int n, dones, ex;
        logic pulsed, st;
        dones = 0; ex = 0; pulsed = 1'b0;
        step(1, 1, 1, 4'd4);
        for (n = 0; n < 200; n++) begin
            checks++;
            if ({inst, busy, in_ready, done} !== {exp_inst, m_busy(), m_rdy(), exp_done}) begin
                failures++;
                $display("FAIL ignored_start step %0d: got %h %b %b %b want %h %b %b %b", n, inst, busy,
                         in_ready, done, exp_inst, m_busy(), m_rdy(), exp_done);
            end
            dones += int'(done);
            ex    += int'(inst[7]);
            if (n > 5 && mq.size() == 0 && !busy) break;
            st = 1'b0;
            if (!pulsed && mq.size() != 0 && mq[0].kind == B_HOST && mq[0].w[2]) begin
                st = 1'b1; pulsed = 1'b1;
            end
            step(1, 1, st, st ? 4'd9 : 4'd0);
        end
        repeat (5) begin
            step(0, 0, 0, 4'd0);
            dones += int'(done);
        end
        checks++;
        if (dones != 1 || ex != 5 || !pulsed) begin
            failures++;
            $display("FAIL ignored_start_result: done_pulses=%0d execs=%0d want 1 5", dones, ex);
        end
    endtask

    task automatic test_random();
        int n;
        logic [3:0] nq;
        for (int p = 0; p < 4; p++) begin
            nq = 4'($urandom_range(0, 15));
            step($urandom_range(0, 1), $urandom_range(0, 1), 1, nq);
            for (n = 0; n < 600; n++) begin
                checks++;
                if ({inst, busy, in_ready, done} !== {exp_inst, m_busy(), m_rdy(), exp_done}) begin
                    failures++;
                    $display("FAIL random pass %0d step %0d: got %h %b %b %b want %h %b %b %b", p, n, inst,
                             busy, in_ready, done, exp_inst, m_busy(), m_rdy(), exp_done);
                end
                if (done === 1'b1) break;
                step($urandom_range(0, 1), $urandom_range(0, 1), $urandom_range(0, 7) == 0,
                     4'($urandom_range(0, 15)));
            end
            checks++;
            if (n >= 600) begin failures++; $display("FAIL random_timeout pass %0d", p); end
        end
    endtask

    initial begin
        reset = 1'b1; start = 1'b0; in_valid = 1'b0; ofifo_valid = 1'b0; n_q = '0;
        test_reset();
        test_full_pass();
        test_host_stalls();
        test_drain_backpressure();
        test_boundaries();
        test_ignored_start();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
